// File: rtl/simplebus_pkg.sv
// Shared types and defaults for the simple-bus burst follower.
// Holds the FSM state enum, default widths and the address-phase count helper.
package simplebus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } sbf_state_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_BURST_LEN = 4;

    function automatic int nph(input int addr_w, input int data_w);
        return addr_w / data_w;
    endfunction

endpackage

// File: rtl/simplebus_mem_array.sv
// Backing store for the burst follower: synchronous write, combinational read.
// Contents start at zero and are never cleared by reset.
module simplebus_mem_array
    import simplebus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/simplebus_burst_follower.sv
// Memory-side simple-bus follower: multi-phase address, single/burst read and write,
// programmable read wait states. Optional write-stall timeout under SBF_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start; MS address chunk captured on start
// ADDR  | shifting in remaining address chunks; read/burst latched on the last one
// RD    | counting wait states, then presenting one read beat per reload
// WR    | accepting one write beat per cycle with dv_in, stalls otherwise
module simplebus_burst_follower
    import simplebus_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int WAIT_W    = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              read,
    input  logic              burst,
    input  logic [DATA_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic              dv_in,
    output logic              dv_out,
    output logic              dv_oe,
    input  logic [WAIT_W-1:0] wait_cfg,
    output logic              busy,
    output logic              err
);

    localparam int NPH  = nph(ADDR_W, DATA_W);
    localparam int PH_W = $clog2(NPH);
    localparam int BT_W = $clog2(BURST_LEN + 1);

    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(NPH - 1);
    localparam logic [BT_W-1:0] BT_BURST = BT_W'(BURST_LEN);
    localparam logic [BT_W-1:0] BT_ONE   = BT_W'(1);

    sbf_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [BT_W-1:0]   beats_q, beats_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              rd_beat;
    logic              timeout_hit;

`ifdef SBF_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT + 1);
    logic [ST_W-1:0] stall_q, stall_d;

    // Timeout fires the cycle after the TIMEOUT-th consecutive stall, from state alone.
    assign timeout_hit = (state_q == WR) && (stall_q == ST_W'(TIMEOUT));

    always_comb begin
        stall_d = '0;
        if ((state_q == WR) && !dv_in && !timeout_hit) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT == 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            phase_q <= '0;
            beats_q <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            beats_q <= beats_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Address chunks shift in from the bottom, so after NPH captures the first lands on top.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        beats_d = beats_q;
        wcnt_d  = wcnt_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = {addr_q[ADDR_W-DATA_W-1:0], address};
                    phase_d = PH_W'(1);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                addr_d  = {addr_q[ADDR_W-DATA_W-1:0], address};
                phase_d = phase_q + 1'b1;
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    beats_d = burst ? BT_BURST : BT_ONE;
                    wcnt_d  = wait_cfg;
                    state_d = read ? RD : WR;
                end
            end
            RD: begin
                if (wcnt_q == '0) begin
                    addr_d  = addr_q + 1'b1;
                    beats_d = beats_q - 1'b1;
                    wcnt_d  = wait_cfg;
                    if (beats_q == BT_ONE) begin
                        state_d = IDLE;
                    end
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            WR: begin
                if (timeout_hit) begin
                    beats_d = '0;
                    state_d = IDLE;
                end else if (dv_in) begin
                    mem_we  = !reset;
                    addr_d  = addr_q + 1'b1;
                    beats_d = beats_q - 1'b1;
                    if (beats_q == BT_ONE) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    simplebus_mem_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clock(clock),
        .we   (mem_we),
        .addr (addr_q),
        .wdata(data_in),
        .rdata(mem_rdata)
    );

    assign rd_beat  = (state_q == RD) && (wcnt_q == '0);
    assign dv_oe    = (state_q == RD);
    assign dv_out   = rd_beat;
    assign data_oe  = rd_beat;
    assign data_out = rd_beat ? mem_rdata : '0;
    assign busy     = (state_q != IDLE);
    assign err      = timeout_hit;

endmodule

// File: tb/tb_simplebus_burst_follower.sv
// Self-checking bench for simplebus_burst_follower; expected read data comes from a
// flat byte-array memory model updated at each accepted write beat.
module tb_simplebus_burst_follower;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 16;
    localparam int BURST_LEN = 4;
    localparam int WAIT_W    = 3;
    localparam int TIMEOUT   = 64;
    localparam int NPH       = ADDR_W / DATA_W;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        read = 1'b0;
    logic        burst = 1'b0;
    logic        dv_in = 1'b0;
    logic [7:0]  address = '0;
    logic [7:0]  data_in = '0;
    logic [2:0]  wait_cfg = '0;
    logic [7:0]  data_out;
    logic        data_oe, dv_out, dv_oe, busy, err;

    int total = 0;
    int bad = 0;

    logic [7:0] model_mem [0:65535];
    logic [7:0] wd [0:3];
    bit         dvpat [0:31];
    int         dvlen;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          w;
        int          exp_cyc;
        logic [7:0]  exp_data;
    } vec_t;
    vec_t vecs [5];

    always #5 clock = ~clock;

    simplebus_burst_follower #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
        .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .read(read), .burst(burst),
        .address(address), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .dv_in(dv_in), .dv_out(dv_out), .dv_oe(dv_oe), .wait_cfg(wait_cfg),
        .busy(busy), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives one write transaction using wd[] and dvpat[0:dvlen-1]; updates the model.
    task automatic write_txn(input logic [15:0] a, input bit b);
        int nb;
        int k;
        nb = b ? BURST_LEN : 1;
        k = 0;
        start = 1'b1; address = a[15:8]; read = 1'b1; burst = ~b;
        step();
        start = 1'b0; address = a[7:0]; read = 1'b0; burst = b;
        step();
        for (int i = 0; i < dvlen; i++) begin
            address = 8'($urandom); read = 1'($urandom); burst = 1'($urandom);
            dv_in = dvpat[i];
            data_in = (dvpat[i] && k < 4) ? wd[k] : 8'($urandom);
            if (dvpat[i] && k < nb) begin
                model_mem[a + 16'(k)] = wd[k];
                k++;
            end
            step();
        end
        dv_in = 1'b0;
        read = 1'b0; burst = 1'b0;
        @(negedge clock);
        check("wr_idle_after_last", busy, 0);
        step();
    endtask

    task automatic read_txn(input logic [15:0] a, input bit b, input int w, input int rst_after,
                            output int first_cyc, output logic [7:0] first_dat);
        int nb, got, cyc, limit;
        logic [15:0] ea;
        nb = b ? BURST_LEN : 1;
        got = 0;
        limit = NPH + (w + 1) * nb + 4;
        first_cyc = -1;
        first_dat = 8'h00;
        start = 1'b1; address = a[15:8]; read = 1'b0; burst = ~b; wait_cfg = 3'(w);
        step();
        start = 1'b1; address = a[7:0]; read = 1'b1; burst = b;
        @(negedge clock);
        check("busy_rise", busy, 1);
        step();
        cyc = 2;
        start = 1'b0; read = 1'b0; burst = 1'b0;
        while (got < nb && cyc < limit) begin
            address = 8'($urandom);
            @(negedge clock);
            check("rd_dv_oe", dv_oe, 1);
            if (dv_out) begin
                ea = a + 16'(got);
                check("rd_beat_cyc", cyc, NPH + w + got * (w + 1));
                check("rd_data_oe", data_oe, 1);
                check("rd_data", data_out, model_mem[ea]);
                if (got == 0) begin
                    first_cyc = cyc;
                    first_dat = data_out;
                end
                got++;
            end else begin
                check("rd_quiet_data_oe", data_oe, 0);
            end
            if (rst_after != 0 && got == rst_after) break;
            step();
            cyc++;
        end
        if (rst_after != 0) begin
            step();
            reset = 1'b1;
            step();
            reset = 1'b0;
            @(negedge clock);
            check("rst_busy", busy, 0);
            check("rst_dv_oe", dv_oe, 0);
            check("rst_data_oe", data_oe, 0);
            check("rst_data_out", data_out, 0);
            step();
        end else begin
            if (got < nb) check("rd_beats_budget", got, nb);
            @(negedge clock);
            check("rd_idle_busy", busy, 0);
            check("rd_idle_dv_oe", dv_oe, 0);
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        logic [7:0] fd;
        int nb, err_cyc, err_cnt, busy_after, cyc;
        bit any_err, all_busy;
        logic [15:0] ra;

        for (int i = 0; i < 65536; i++) model_mem[i] = 8'h00;

        vecs[0] = '{16'h0406, 8'hDC, 0, 2, 8'hDC};
        vecs[1] = '{16'h0406, 8'hDC, 5, 7, 8'hDC};
        vecs[2] = '{16'h1234, 8'h5A, 3, 5, 8'h5A};
        vecs[3] = '{16'h00FF, 8'hA5, 1, 3, 8'hA5};
        vecs[4] = '{16'hFFFF, 8'h01, 7, 9, 8'h01};

        reset = 1'b1;
        step();
        step();
        @(negedge clock);
        check("reset_busy", busy, 0);
        check("reset_dv_oe", dv_oe, 0);
        check("reset_dv_out", dv_out, 0);
        check("reset_data_oe", data_oe, 0);
        check("reset_data_out", data_out, 0);
        check("reset_err", err, 0);
        step();
        reset = 1'b0;
        step();

        // Single write then single read, with the first-beat cycle fixed per vector.
        for (int i = 0; i < 5; i++) begin
            wd[0] = vecs[i].wdata;
            dvpat[0] = 1'b1;
            dvlen = 1;
            write_txn(vecs[i].addr, 1'b0);
            read_txn(vecs[i].addr, 1'b0, vecs[i].w, 0, fc, fd);
            check("vec_first_cyc", fc, vecs[i].exp_cyc);
            check("vec_data", fd, vecs[i].exp_data);
        end

        // Burst across the top of the address space.
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
        for (int i = 0; i < 4; i++) dvpat[i] = 1'b1;
        dvlen = 4;
        write_txn(16'hFFFE, 1'b1);
        read_txn(16'hFFFE, 1'b1, 0, 0, fc, fd);
        check("wrap_first", fd, 8'h11);
        read_txn(16'h0000, 1'b0, 0, 0, fc, fd);
        check("wrap_mem0000", fd, 8'h33);
        read_txn(16'h0001, 1'b0, 2, 0, fc, fd);
        check("wrap_mem0001", fd, 8'h44);

        // Write stalls: pattern 1,0,0,1,1,0,1 writes exactly four words.
        wd[0] = 8'hA1; wd[1] = 8'hB2; wd[2] = 8'hC3; wd[3] = 8'hD4;
        dvpat[0] = 1; dvpat[1] = 0; dvpat[2] = 0; dvpat[3] = 1;
        dvpat[4] = 1; dvpat[5] = 0; dvpat[6] = 1;
        dvlen = 7;
        write_txn(16'h3000, 1'b1);
        read_txn(16'h3000, 1'b1, 1, 0, fc, fd);
        check("stall_first", fd, 8'hA1);
        read_txn(16'h3003, 1'b0, 0, 0, fc, fd);
        check("stall_last", fd, 8'hD4);
        read_txn(16'h3004, 1'b0, 0, 0, fc, fd);
        check("stall_no_extra", fd, 8'h00);

        // Reset after two beats of a burst read; memory must survive.
        read_txn(16'h3000, 1'b1, 2, 2, fc, fd);
        read_txn(16'h3002, 1'b0, 0, 0, fc, fd);
        check("post_rst_single", fd, 8'hC3);
        read_txn(16'h3000, 1'b1, 0, 0, fc, fd);

        // A write beat coincident with reset is discarded.
        start = 1'b1; address = 8'h31;
        step();
        start = 1'b0; address = 8'h00; read = 1'b0; burst = 1'b0;
        step();
        dv_in = 1'b1; data_in = 8'hEE; reset = 1'b1;
        step();
        dv_in = 1'b0; reset = 1'b0;
        @(negedge clock);
        check("wr_rst_busy", busy, 0);
        step();
        read_txn(16'h3100, 1'b0, 0, 0, fc, fd);
        check("wr_rst_discard", fd, 8'h00);

        // Randomized transactions in a small prefilled window.
        for (int j = 0; j < 9; j++) begin
            for (int i = 0; i < 4; i++) begin
                wd[i] = 8'($urandom);
                dvpat[i] = 1'b1;
            end
            dvlen = 4;
            write_txn(16'h2000 + 16'(4 * j), 1'b1);
        end
        for (int t = 0; t < 40; t++) begin
            bit b;
            b = 1'($urandom);
            ra = 16'h2000 + 16'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                nb = b ? BURST_LEN : 1;
                dvlen = 0;
                for (int i = 0; i < nb; i++) begin
                    int s;
                    s = $urandom_range(0, 2);
                    for (int z = 0; z < s; z++) begin
                        dvpat[dvlen] = 1'b0;
                        dvlen++;
                    end
                    dvpat[dvlen] = 1'b1;
                    dvlen++;
                    wd[i] = 8'($urandom);
                end
                write_txn(ra, b);
            end else begin
                read_txn(ra, b, $urandom_range(0, 3), 0, fc, fd);
            end
        end

        // Burst write with dv_in held low.
        start = 1'b1; address = 8'h40;
        step();
        start = 1'b0; address = 8'h00; read = 1'b0; burst = 1'b1;
        step();
        dv_in = 1'b0; burst = 1'b0;
        cyc = 2;
        err_cyc = -1; err_cnt = 0; busy_after = -1;
        any_err = 1'b0; all_busy = 1'b1;
        while (cyc < NPH + TIMEOUT + 4) begin
            @(negedge clock);
            if (err) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = cyc;
            end
            if (err_cyc >= 0 && cyc == err_cyc + 1) busy_after = int'(busy);
            any_err |= err;
            all_busy &= busy;
            step();
            cyc++;
        end
`ifdef SBF_TIMEOUT_EN
        check("timeout_err_cyc", err_cyc, NPH + TIMEOUT);
        check("timeout_err_len", err_cnt, 1);
        check("timeout_busy_after", busy_after, 0);
`else
        check("no_timeout_busy", all_busy, 1);
        check("no_timeout_err", any_err, 0);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check("final_idle", busy, 0);
        step();
        read_txn(16'h4000, 1'b1, 0, 0, fc, fd);
        check("timeout_no_write", fd, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
